// File: rtl/bound_flasher_param.sv
// Thermometer-coded LED sequencer. On FLICK it runs a three-phase up/down
// pattern with kickback at LOW and 0, a step prescaler, and phase/busy status.
module bound_flasher_param #(
    parameter int N        = 16,
    parameter int LOW      = 5,
    parameter int MID      = 10,
    parameter int STEP_DIV = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         FLICK,
    output logic [N-1:0] LED,
    output logic [2:0]   PHASE,
    output logic         BUSY
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [CW-1:0] N_C      = CW'(N);
    localparam logic [CW-1:0] LOW_C    = CW'(LOW);
    localparam logic [CW-1:0] MID_C    = CW'(MID);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] DIV_LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);

    if (!(LOW > 0 && LOW < MID && MID < N && STEP_DIV >= 1)) begin : g_param_check
        $error("bound_flasher_param: require 0 < LOW < MID < N and STEP_DIV >= 1");
    end

    // state | meaning
    // IDLE  | dark, waiting for FLICK (acts on every edge)
    // UP1   | climb to N        DN1 | fall to LOW
    // UP2   | climb to MID      DN2 | fall to 0
    // UP3   | climb to LOW      DN3 | fall to 0, then IDLE
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] lim;
    logic          tick;
    logic          is_up;
    logic          at_kick;

    // With STEP_DIV = 1 the prescaler is pinned at 0, so every edge ticks.
    assign tick = (presc_q == DIV_LAST);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        is_up   = (phase_q == UP1) || (phase_q == UP2) || (phase_q == UP3);
        at_kick = (cnt_q == LOW_C) || (cnt_q == '0);

        case (phase_q)
            UP1:      lim = N_C;
            UP2:      lim = MID_C;
            UP3, DN1: lim = LOW_C;
            default:  lim = '0;
        endcase

        if (phase_q == IDLE) begin
            presc_d = '0;
            cnt_d   = '0;
            if (FLICK) begin
                phase_d = UP1;
                cnt_d   = ONE_C;
            end
        end else if (tick) begin
            presc_d = '0;
            if (phase_q > DN3 || cnt_q > N_C) begin
                phase_d = IDLE;
                cnt_d   = '0;
            end else if (is_up) begin
                if (cnt_q == lim) begin
                    phase_d = phase_e'(phase_q + 3'd1);
                    cnt_d   = cnt_q - ONE_C;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end else if (FLICK && at_kick) begin
                // kickback re-enters the UP phase paired with this DN phase
                phase_d = phase_e'(phase_q - 3'd1);
                cnt_d   = cnt_q + ONE_C;
            end else if (cnt_q == lim) begin
                if (phase_q == DN3) begin
                    phase_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    phase_d = phase_e'(phase_q + 3'd1);
                    cnt_d   = cnt_q + ONE_C;
                end
            end else begin
                cnt_d = cnt_q - ONE_C;
            end
        end else begin
            presc_d = presc_q + P_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        LED = '0;
        for (int i = 0; i < N; i++) begin
            LED[i] = (CW'(i) < cnt_q);
        end
    end

    assign PHASE = phase_q;
    assign BUSY  = (phase_q != IDLE);

endmodule

// File: tb/tb_bound_flasher_param.sv
// Bench for bound_flasher_param: default instance against a leg-table
// reference model, plus an N=8/LOW=2/MID=5/STEP_DIV=4 instance.
module tb_bound_flasher_param;

    logic        clk = 1'b0;
    logic        rst_a, flick_a, rst_b, flick_b;
    logic [15:0] led_a;
    logic [2:0]  phase_a;
    logic        busy_a;
    logic [7:0]  led_b;
    logic [2:0]  phase_b;
    logic        busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ma_leg, ma_cnt, edge_n;

    always #5 clk = ~clk;

    bound_flasher_param dut_a (
        .CLK(clk), .RST(rst_a), .FLICK(flick_a),
        .LED(led_a), .PHASE(phase_a), .BUSY(busy_a)
    );

    bound_flasher_param #(.N(8), .LOW(2), .MID(5), .STEP_DIV(4)) dut_b (
        .CLK(clk), .RST(rst_b), .FLICK(flick_b),
        .LED(led_b), .PHASE(phase_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leg 0..5 = UP1,DN1,UP2,DN2,UP3,DN3 with their turn-around counts; -1 = idle.
    task automatic mstep(input int n, input int low, input int mid, input bit f,
                         inout int leg, inout int cnt);
        int lim[6];
        lim = '{n, low, mid, 0, low, 0};
        if (leg < 0) begin
            if (f) begin leg = 0; cnt = 1; end
        end else if (leg % 2 == 0) begin
            if (cnt == lim[leg]) begin leg++; cnt--; end
            else cnt++;
        end else if (f && (cnt == low || cnt == 0)) begin
            leg--; cnt++;
        end else if (cnt == lim[leg]) begin
            if (leg == 5) begin leg = -1; cnt = 0; end
            else begin leg++; cnt++; end
        end else begin
            cnt--;
        end
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_led"},   32'(led_a),   (32'd1 << ma_cnt) - 32'd1);
        chk({tag, "_phase"}, 32'(phase_a), 32'(ma_leg + 1));
        chk({tag, "_busy"},  32'(busy_a),  32'(ma_leg >= 0));
    endtask

    task automatic step_a(input bit f, input string tag);
        @(negedge clk);
        flick_a = f;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst_a) mstep(16, 5, 10, f, ma_leg, ma_cnt);
        check_a(tag);
    endtask

    task automatic run_to_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (phase_a == 3'd0) break;
            step_a(1'b0, tag);
        end
        chk({tag, "_idle"}, 32'(phase_a), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; flick_a = 1'b0; flick_b = 1'b0;
        ma_leg = -1; ma_cnt = 0; edge_n = 0;

        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2;
        check_a("rst");
        chk("rst_b_led",   32'(led_b),   32'd0);
        chk("rst_b_phase", 32'(phase_b), 32'd0);
        chk("rst_b_busy",  32'(busy_b),  32'd0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // normal one-pulse run
        edge_n = 0;
        step_a(1'b1, "norm");
        for (int i = 2; i <= 16; i++) step_a(1'b0, "norm");
        chk("norm_peak", 32'(led_a), 32'hFFFF);
        run_to_idle("norm");
        chk("norm_len", edge_n, 53);
        chk("norm_led_end", 32'(led_a), 32'd0);

        // DN2: FLICK at cnt 7 ignored, at cnt 5 kicks back to UP2
        edge_n = 0;
        step_a(1'b1, "k2");
        for (int i = 2; i <= 35; i++) step_a(1'b0, "k2");
        step_a(1'b1, "k2");
        chk("k2_nokick_phase", 32'(phase_a), 32'd4);
        chk("k2_nokick_led",   32'(led_a),   32'h003F);
        step_a(1'b0, "k2");
        step_a(1'b1, "k2");
        chk("k2_kick_phase", 32'(phase_a), 32'd3);
        chk("k2_kick_led",   32'(led_a),   32'h003F);
        for (int i = 0; i < 4; i++) step_a(1'b0, "k2");
        chk("k2_reclimb_led", 32'(led_a), 32'h03FF);
        run_to_idle("k2");
        chk("k2_len", edge_n, 63);

        // DN1 kick at 5 back to UP1
        edge_n = 0;
        step_a(1'b1, "k1");
        for (int i = 2; i <= 27; i++) step_a(1'b0, "k1");
        step_a(1'b1, "k1");
        chk("k1_kick_phase", 32'(phase_a), 32'd1);
        for (int i = 0; i < 10; i++) step_a(1'b0, "k1");
        chk("k1_full_led", 32'(led_a), 32'hFFFF);
        run_to_idle("k1");
        chk("k1_len", edge_n, 75);

        // DN3 kick at 0 back to UP3
        edge_n = 0;
        step_a(1'b1, "k3");
        for (int i = 2; i <= 52; i++) step_a(1'b0, "k3");
        step_a(1'b1, "k3");
        chk("k3_kick_phase", 32'(phase_a), 32'd5);
        chk("k3_kick_led",   32'(led_a),   32'h0001);
        run_to_idle("k3");
        chk("k3_len", edge_n, 63);

        // FLICK held through all of UP1 has no effect
        edge_n = 0;
        step_a(1'b1, "uph");
        for (int i = 2; i <= 17; i++) step_a(1'b1, "uph");
        chk("uph_phase", 32'(phase_a), 32'd2);
        chk("uph_led",   32'(led_a),   32'h7FFF);
        run_to_idle("uph");
        chk("uph_len", edge_n, 53);

        // narrow pulses between edges are never sampled
        edge_n = 0;
        step_a(1'b1, "burst");
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            #1 flick_a = 1'b1;
            #3 flick_a = 1'b0;
            @(posedge clk);
            #1;
            edge_n++;
            mstep(16, 5, 10, 1'b0, ma_leg, ma_cnt);
            check_a("burst");
        end
        run_to_idle("burst");
        chk("burst_len", edge_n, 53);

        // async reset mid-UP1 between edges, then reset held with FLICK high
        edge_n = 0;
        step_a(1'b1, "ar");
        for (int i = 2; i <= 9; i++) step_a(1'b0, "ar");
        chk("ar_pre_led", 32'(led_a), 32'h01FF);
        #1 rst_a = 1'b0; flick_a = 1'b1; ma_leg = -1; ma_cnt = 0;
        #2 check_a("ar_async");
        #1 rst_a = 1'b1;
        @(posedge clk);
        #1;
        mstep(16, 5, 10, 1'b1, ma_leg, ma_cnt);
        check_a("ar_restart");
        #1 rst_a = 1'b0; ma_leg = -1; ma_cnt = 0;
        step_a(1'b1, "ar_hold");
        step_a(1'b1, "ar_hold");
        @(negedge clk);
        rst_a = 1'b1; flick_a = 1'b1;
        @(posedge clk);
        #1;
        edge_n = 1;
        mstep(16, 5, 10, 1'b1, ma_leg, ma_cnt);
        check_a("ar_first");
        chk("ar_first_phase", 32'(phase_a), 32'd1);
        run_to_idle("ar");
        chk("ar_len", edge_n, 53);

        // random FLICK traffic against the model
        for (int i = 0; i < 1000; i++) step_a($urandom_range(0, 4) == 0, "rnd");
        run_to_idle("rnd");

        // prescaled instance
        begin : b_run
            int sq[$];
            int sl[$];
            int leg, cnt, prev, last_j, nchg, peak, e_cnt, e_leg;
            leg = 0; cnt = 1;
            while (leg >= 0 && sq.size() < 200) begin
                sq.push_back(cnt);
                sl.push_back(leg);
                mstep(8, 2, 5, 1'b0, leg, cnt);
            end
            prev = 0; nchg = 0; peak = 0; last_j = 0;
            @(negedge clk);
            flick_b = 1'b1;
            for (int j = 0; j <= 110; j++) begin
                @(posedge clk);
                #1;
                flick_b = 1'b0;
                e_cnt = (j / 4 < sq.size()) ? sq[j / 4] : 0;
                e_leg = (j / 4 < sq.size()) ? sl[j / 4] : -1;
                chk("b_led",   32'(led_b),   (32'd1 << e_cnt) - 32'd1);
                chk("b_phase", 32'(phase_b), 32'(e_leg + 1));
                if (int'(led_b) != prev) begin
                    if (nchg > 0) chk("b_spacing", j - last_j, 4);
                    nchg++;
                    last_j = j;
                    prev = int'(led_b);
                end
                if (int'(led_b) > peak) peak = int'(led_b);
            end
            chk("b_changes",  nchg, 26);
            chk("b_peak",     peak, 32'hFF);
            chk("b_busy_end", 32'(busy_b), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
